// File: rtl/dis_arbiter.sv
// Round-robin arbiter that shares the seven-segment display between four
// 32-bit debug sources, holding each granted word for at least HOLD_CYC cycles.
module dis_arbiter #(
  parameter logic [15:0] HOLD_CYC = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] src_data,
  input  logic         lock,
  output logic [3:0]   ack,
  output logic [31:0]  disp_data,
  output logic [1:0]   disp_src,
  output logic         busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [15:0] RELOAD = HOLD_CYC - 16'd1;

  logic [0:0]  state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [1:0]  last_q,  last_d;
  logic [31:0] data_q,  data_d;
  logic [1:0]  src_q,   src_d;
  logic [3:0]  ack_q,   ack_d;

  logic [1:0]  win;
  logic [1:0]  idx;
  logic        hit;
  logic        any_req;
  logic        grant;

  assign any_req = |req;

  // Search starts just after the last winner so it ends up lowest priority.
  always_comb begin
    win = '0;
    idx = '0;
    hit = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_q + k[1:0];
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    grant = 1'b0;
    if (state_q == S_IDLE)
      grant = any_req;
    else if (cnt_q == '0 && !lock)
      grant = any_req;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    src_d   = src_q;
    ack_d   = '0;
    if (grant) begin
      state_d     = S_HOLD;
      cnt_d       = RELOAD;
      last_d      = win;
      data_d      = src_data[32*win +: 32];
      src_d       = win;
      ack_d[win]  = 1'b1;
    end else if (state_q == S_HOLD) begin
      if (cnt_q != '0)
        cnt_d = cnt_q - 16'd1;
      else if (!lock)
        state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      data_q  <= '0;
      src_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign disp_data = data_q;
  assign disp_src  = src_q;
  assign busy      = (state_q == S_HOLD);

endmodule
